acc_post_fx: RTL and testbench
==============================

ACC_POST_FX -- requirements
Module: acc_post_fx

Interface
REQ-001 Parameter NUBITS, default 32: data width of acc, gain and out.
REQ-002 Parameter NUGAIN, default 128: constant divisor used when GAIN_PORT=0.
REQ-003 Parameter GAIN_PORT, default 0: 1 = divisor taken from port gain; 0 = divisor is NUGAIN and port gain is ignored.
REQ-004 Parameter NORMS, default 1: 1 = normalisation (divide) hardware present.
REQ-005 Parameter PSET, default 1: 1 = negative-clamp hardware present.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  request pulse; sampled only when busy=0.
REQ-009 mode  input  2  00 pass, 01 norm, 10 pset (clamp negative to 0), 11 norm then pset.
REQ-010 acc  input  NUBITS  two's-complement operand.
REQ-011 gain  input  NUBITS  unsigned divisor.
REQ-012 out  output  NUBITS  registered result.
REQ-013 busy  output  1  high while a division is in progress.
REQ-014 done  output  1  one-cycle pulse: out is valid.
REQ-015 err  output  1  divide-by-zero flag for the current result.

Function
REQ-016 FSM states: IDLE, DIV, FIX, DONE. busy=1 in DIV and FIX only.
REQ-017 start is accepted in IDLE or DONE; mode, acc and the divisor are latched on the accepting edge.
REQ-018 start in DIV or FIX is ignored: no latch and no effect on the operation in flight.
REQ-019 Effective mode: if NORMS=0, 01 maps to 00 and 11 maps to 10; if PSET=0, 10 maps to 00 and 11 maps to 01.
REQ-020 Effective mode 00 or 10 on the accepting edge: out is loaded on that edge, the state goes to DONE, and done=1 in the next cycle (1-cycle latency).
REQ-021 Mode 00 result is acc unchanged; mode 10 result is 0 if acc[NUBITS-1]=1, else acc.
REQ-022 Effective mode 01 or 11: the FSM goes to DIV and performs an unsigned restoring division of |acc| by the divisor, one quotient bit per cycle, for exactly NUBITS cycles.
REQ-023 |acc| is held in NUBITS unsigned bits, so |−2^(NUBITS−1)| = 2^(NUBITS−1) is represented exactly.
REQ-024 FIX, one cycle: negate the quotient if acc was negative (signed division truncating toward zero), apply the clamp for mode 11, load out, go to DONE.
REQ-025 Division latency: done=1 in the cycle after edge t+NUBITS+1, where t is the accepting edge; NUBITS+1 cycles in total.
REQ-026 Divisor = 0: err=1; result = 2^(NUBITS−1)−1 if acc ≥ 0, else −2^(NUBITS−1); the mode-11 clamp still applies; the same latency as a normal division.
REQ-027 err updates together with out; it is cleared by any later result with a nonzero divisor or with a pass/pset mode.
REQ-028 DONE lasts exactly one cycle and then returns to IDLE, unless start is accepted, in which case it proceeds as from IDLE. done is never high for 2 consecutive cycles from one request.
REQ-029 out holds its value between results; acc and gain may change freely after the accepting edge.

Reset
REQ-030 rst=0 at a rising edge forces: state IDLE, out=0, busy=0, done=0, err=0, internal divider registers 0.
REQ-031 Reset during DIV or FIX aborts the operation: no done pulse and out stays 0.
REQ-032 A start sampled in the same cycle as rst=0 is discarded.

Verification (NUBITS=32, GAIN_PORT=1, NORMS=PSET=1)
REQ-033 mode=01, acc=1000, gain=128 -> out=7, err=0; busy for 33 cycles, then done pulses 33 cycles after start.
REQ-034 mode=01, acc=0xFFFFFC18 (−1000), gain=128 -> out=0xFFFFFFF9 (−7); with mode=11 -> out=0.
REQ-035 mode=10, acc=0x80000000 -> out=0 with done the next cycle; mode=10, acc=5 -> out=5; mode=00, acc=0xDEADBEEF -> out=0xDEADBEEF.
REQ-036 mode=01, acc=0xFFFFFFFB, gain=0 -> out=0x80000000, err=1; the next request with mode=00, acc=3 -> out=3, err=0.
REQ-037 start pulsed at cycle 5 of a division with different acc -> ignored, first result unchanged; rst=0 at cycle 10 of a division -> busy=0, no done, out=0.
REQ-038 start asserted in the DONE cycle with mode=00, acc=9 -> accepted, out=9 and done=1 in the following cycle.

Source files
------------

// File: rtl/acc_post_fx.sv
// Accumulator post-processing: pass, divide-normalise, negative clamp, or normalise then clamp.
// Signed division is a multi-cycle unsigned restoring divider on |acc|, followed by a sign-fix cycle.
`timescale 1ns/1ps
module acc_post_fx #(
    parameter int unsigned NUBITS    = 32,
    parameter int unsigned NUGAIN    = 128,
    parameter int unsigned GAIN_PORT = 0,
    parameter int unsigned NORMS     = 1,
    parameter int unsigned PSET      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [NUBITS-1:0] acc,
    input  logic [NUBITS-1:0] gain,
    output logic [NUBITS-1:0] out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CW = (NUBITS > 1) ? $clog2(NUBITS) : 1;
    localparam logic [NUBITS-1:0] INT_MIN = {1'b1, {(NUBITS-1){1'b0}}};
    localparam logic [NUBITS-1:0] INT_MAX = ~INT_MIN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NUBITS-1:0] out_q, out_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUBITS-1:0] rem_q, rem_d;
    logic [NUBITS-1:0] quo_q, quo_d;
    logic [NUBITS-1:0] div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              pset_q, pset_d;

    logic              eff_norm_c;
    logic              eff_pset_c;
    logic [NUBITS-1:0] divisor_c;
    logic [NUBITS-1:0] acc_abs_c;
    logic [NUBITS:0]   rem_sh_c;
    logic [NUBITS:0]   diff_c;
    logic              borrow_c;
    logic [NUBITS-1:0] fix_c;

    // Operand preparation and one restoring-division step
    always_comb begin
        eff_norm_c = mode[0] && (NORMS != 0);
        eff_pset_c = mode[1] && (PSET != 0);
        divisor_c  = (GAIN_PORT != 0) ? gain : NUBITS'(NUGAIN);
        acc_abs_c  = acc[NUBITS-1] ? (~acc + NUBITS'(1)) : acc;
        rem_sh_c   = {rem_q, quo_q[NUBITS-1]};
        diff_c     = rem_sh_c - {1'b0, div_q};
        borrow_c   = diff_c[NUBITS];
    end

    // Sign fix, divide-by-zero saturation and optional clamp
    always_comb begin
        fix_c = neg_q ? (~quo_q + NUBITS'(1)) : quo_q;
        if (div_q == '0) begin
            fix_c = neg_q ? INT_MIN : INT_MAX;
        end
        if (pset_q && fix_c[NUBITS-1]) begin
            fix_c = '0;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        err_d   = err_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        pset_d  = pset_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    neg_d  = acc[NUBITS-1];
                    pset_d = eff_pset_c;
                    if (eff_norm_c) begin
                        quo_d   = acc_abs_c;
                        rem_d   = '0;
                        div_d   = divisor_c;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end else begin
                        out_d   = (eff_pset_c && acc[NUBITS-1]) ? '0 : acc;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV: begin
                rem_d = borrow_c ? rem_sh_c[NUBITS-1:0] : diff_c[NUBITS-1:0];
                quo_d = NUBITS'({quo_q, ~borrow_c});
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUBITS - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                out_d   = fix_c;
                err_d   = (div_q == '0);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_DIV) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            pset_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            pset_q  <= pset_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_acc_post_fx.sv
// Scoreboard bench for acc_post_fx (32-bit, gain from port, norm and clamp present).
`timescale 1ns/1ps
module tb_acc_post_fx;

    localparam int unsigned NB = 32;
    localparam int DIV_LAT = 33;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [NB-1:0] acc = '0;
    logic [NB-1:0] gain = '0;
    logic [NB-1:0] out;
    logic          busy;
    logic          done;
    logic          err;

    acc_post_fx #(
        .NUBITS(NB), .NUGAIN(128), .GAIN_PORT(1), .NORMS(1), .PSET(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .acc(acc), .gain(gain),
        .out(out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NB-1:0] o;
        logic          e;
        int            c;
        string         name;
    } exp_t;

    typedef struct {
        logic [1:0]    m;
        logic [NB-1:0] a;
        logic [NB-1:0] g;
        logic [NB-1:0] o;
        logic          e;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_out"}, 64'(out), 64'(e.o));
                check({e.name, "_err"}, 64'(err), 64'(e.e));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.c));
            end
        end
    end

    // Issue one request from a negedge; inputs are scrambled right after acceptance
    task automatic drive(input logic [1:0] m, input logic [NB-1:0] a, input logic [NB-1:0] g,
                         input logic [NB-1:0] o, input logic e, input string name);
        exp_t x;
        mode  = m;
        acc   = a;
        gain  = g;
        start = 1'b1;
        x.o = o;
        x.e = e;
        x.c = cyc + 1 + (m[0] ? DIV_LAT : 0);
        x.name = name;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        mode  = 2'($urandom);
        acc   = $urandom;
        gain  = $urandom;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    vec_t vt[17] = '{
        '{2'b01, 32'hFFFFFC18, 32'd128,      32'hFFFFFFF9, 1'b0},
        '{2'b11, 32'hFFFFFC18, 32'd128,      32'h00000000, 1'b0},
        '{2'b10, 32'h80000000, 32'd0,        32'h00000000, 1'b0},
        '{2'b10, 32'h00000005, 32'd0,        32'h00000005, 1'b0},
        '{2'b00, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0},
        '{2'b01, 32'hFFFFFFFB, 32'd0,        32'h80000000, 1'b1},
        '{2'b00, 32'h00000003, 32'd0,        32'h00000003, 1'b0},
        '{2'b01, 32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF, 1'b1},
        '{2'b01, 32'd1000,     32'd128,      32'd7,        1'b0},
        '{2'b11, 32'h00000000, 32'd0,        32'h7FFFFFFF, 1'b1},
        '{2'b01, 32'h80000000, 32'd1,        32'h80000000, 1'b0},
        '{2'b11, 32'h80000000, 32'd1,        32'h00000000, 1'b0},
        '{2'b01, 32'd100,      32'd7,        32'd14,       1'b0},
        '{2'b01, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0},
        '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
        '{2'b11, 32'hFFFFFFFB, 32'd0,        32'h00000000, 1'b1},
        '{2'b10, 32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF, 1'b0}
    };

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int bc;
        exp_t x;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", 64'(out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic division with busy-length measurement
        drive(2'b01, 32'd1000, 32'd128, 32'd7, 1'b0, "div_pos");
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(bc), 64'd33);
        wait_empty();

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].m, vt[i].a, vt[i].g, vt[i].o, vt[i].e, $sformatf("vec%0d", i));
            wait_empty();
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_hold", i), 64'(out), 64'(vt[i].o));
        end

        // Start during a division is ignored
        drive(2'b01, 32'd1000, 32'd128, 32'd7, 1'b0, "ignore");
        repeat (3) @(negedge clk);
        mode  = 2'b00;
        acc   = 32'd5000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();

        // Start accepted in the DONE cycle
        mode  = 2'b10;
        acc   = 32'd5;
        start = 1'b1;
        x.o = 32'd5; x.e = 1'b0; x.c = cyc + 1; x.name = "pre_done";
        sb.push_back(x);
        @(negedge clk);
        check("done_cycle_seen", 64'(done), 64'd1);
        mode  = 2'b00;
        acc   = 32'd9;
        x.o = 32'd9; x.e = 1'b0; x.c = cyc + 1; x.name = "start_in_done";
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        wait_empty();

        // Reset during a division aborts it
        drive(2'b01, 32'd1000, 32'd128, 32'd7, 1'b0, "abort");
        repeat (9) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out", 64'(out), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_out_after", 64'(out), 64'd0);

        // Start coincident with reset is discarded
        mode  = 2'b00;
        acc   = 32'd9;
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        check("rst_start_done", 64'(done), 64'd0);
        check("rst_start_out", 64'(out), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_start_out_later", 64'(out), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
